button_event_gen: RTL



---
 rtl/button_event_gen_pkg.sv | 15 +
 rtl/button_event_gen_if.sv | 21 ++
 rtl/button_event_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator: FSM state encoding and
// default tick counts for a 5 kHz clock.
package btn_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    HELD    = 2'd3
  } btn_state_t;

  localparam int HOLD_TICKS_DEF   = 2500;  // 0.5 s at 5 kHz
  localparam int REPEAT_TICKS_DEF = 500;   // 100 ms at 5 kHz

endpackage

// File: rtl/button_event_gen_if.sv
// Debounced button level in, event strobes and held level out.
interface button_event_gen_if;

  logic debounced_button;
  logic press_pulse;
  logic release_pulse;
  logic hold_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output debounced_button,
    input  press_pulse, release_pulse, hold_pulse, repeat_pulse, held
  );

  modport slave (
    input  debounced_button,
    output press_pulse, release_pulse, hold_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/release/hold/repeat
// strobes plus a held level; all outputs registered.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  button_event_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit               REPEAT_EN   = (REPEAT_TICKS != 0);

  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             r_hold;
  logic             r_repeat;
  logic             r_held;
  logic             w_btn;

  assign w_btn = bus.debounced_button;

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.hold_pulse    = r_hold;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = r_held;

  // NOTE: sequential state uses non-blocking (<=) assignments only; reset is
  // sampled on the clock edge, so it sits first inside the clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARM;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
      r_repeat  <= 1'b0;

      case (r_state)
        // A button still down from before reset must be let go first.
        ARM: begin
          r_cnt <= '0;
          if (!w_btn) r_state <= IDLE;
        end

        IDLE: begin
          r_cnt <= '0;
          if (w_btn) begin
            r_state <= PRESSED;
            r_press <= 1'b1;
          end
        end

        // Release is tested first so it wins over a same-cycle terminal count.
        PRESSED: begin
          if (!w_btn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_hold  <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        HELD: begin
          if (!w_btn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else if (REPEAT_EN && r_cnt == REPEAT_LAST) begin
            r_cnt    <= '0;
            r_repeat <= 1'b1;
          end else if (REPEAT_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ARM;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
